// File: rtl/clk_en_divider_multi.sv
// clk_en_divider_multi
//   Multi-channel, run-time programmable clock-enable generator on clk_100MHz.
//   Each channel counts 0..div_act-1. It produces a one-cycle tick at count 0
//   and a square wave that is high while count < div_act/2. A new divisor can
//   be loaded at any time. It takes effect at the end of the period in
//   progress, on a restart, or while the channel is disabled.
//
// Ports
//   clk_100MHz    system clock
//   reset         asynchronous, active-high reset
//   ch_en         per-channel run enable (level)
//   div_val       packed divisors, channel i at [i*DIV_W +: DIV_W]
//   div_load      per-channel one-cycle load request for div_val
//   sync_restart  one-cycle pulse, phase-aligns all enabled channels
//   tick          one-cycle strobe per period (registered)
//   clk_out       registered square wave, period = divisor; probe use only
//   div_busy      a loaded divisor is waiting for the next wrap
//   div_err       one-cycle pulse when a load of a divisor < 2 is rejected
module clk_en_divider_multi #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic                    clk_100MHz,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic                    sync_restart,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       div_busy,
  output logic [NUM_CH-1:0]       div_err
);

  localparam logic [DIV_W-1:0] DivRst = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] One    = DIV_W'(1);
  localparam logic [DIV_W-1:0] Two    = DIV_W'(2);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic [DIV_W-1:0] new_val, eff_pend;
    logic             busy_q, busy_d;
    logic             run_q;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic             err_q, err_d;
    logic             load_ok, eff_busy, wrap, restart;

    always_comb begin
      new_val  = div_val[i*DIV_W +: DIV_W];
      load_ok  = div_load[i] && (new_val >= Two);
      err_d    = div_load[i] && (new_val < Two);
      // A load in this cycle supersedes whatever is pending.
      eff_pend = load_ok ? new_val : pend_q;
      eff_busy = load_ok || busy_q;
      // div_act >= 2 always, so the subtraction cannot underflow.
      wrap     = (cnt_q == div_act_q - One);
      // Disabled, first enabled cycle, sync pulse or wrap all restart the
      // phase at 0 and are the only points where a pending divisor is applied.
      restart  = !ch_en[i] || !run_q || sync_restart || wrap;

      cnt_d     = cnt_q + One;
      div_act_d = div_act_q;
      pend_d    = eff_pend;
      busy_d    = eff_busy;
      if (restart) begin
        cnt_d  = '0;
        busy_d = 1'b0;
        if (eff_busy) begin
          div_act_d = eff_pend;
        end
      end

      // Outputs are registered images of the next-state count.
      tick_d = ch_en[i] && (cnt_d == '0);
      clk_d  = ch_en[i] && (cnt_d < (div_act_d >> 1));
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
        cnt_q     <= '0;
        div_act_q <= DivRst;
        pend_q    <= '0;
        busy_q    <= 1'b0;
        run_q     <= 1'b0;
        tick_q    <= 1'b0;
        clk_q     <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        div_act_q <= div_act_d;
        pend_q    <= pend_d;
        busy_q    <= busy_d;
        run_q     <= ch_en[i];
        tick_q    <= tick_d;
        clk_q     <= clk_d;
        err_q     <= err_d;
      end
    end

    assign tick[i]     = tick_q;
    assign clk_out[i]  = clk_q;
    assign div_busy[i] = busy_q;
    assign div_err[i]  = err_q;
  end

endmodule
